// File: rtl/dm_sba_arbiter.sv
// Shares the debug module system-bus master port between NrReq requesters, routing responses in order.
// Build option: define DM_SBA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dm_sba_arbiter #(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrReq-1:0]                     req_i,
  input  logic [NrReq-1:0][BusWidth-1:0]       add_i,
  input  logic [NrReq-1:0]                     we_i,
  input  logic [NrReq-1:0][BusWidth-1:0]       wdata_i,
  input  logic [NrReq-1:0][BusWidth/8-1:0]     be_i,
  output logic [NrReq-1:0]                     gnt_o,
  output logic [NrReq-1:0]                     r_valid_o,
  output logic [BusWidth-1:0]                  r_rdata_o,
  output logic                                 master_req_o,
  output logic [BusWidth-1:0]                  master_add_o,
  output logic                                 master_we_o,
  output logic [BusWidth-1:0]                  master_wdata_o,
  output logic [BusWidth/8-1:0]                master_be_o,
  input  logic                                 master_gnt_i,
  input  logic                                 master_r_valid_i,
  input  logic [BusWidth-1:0]                  master_r_rdata_i,
  output logic                                 err_o
);
  localparam int unsigned IdxW = $clog2(NrReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;

  idx_t            sel;
  idx_t            sel_free;
  idx_t            lock_idx_q;
  logic            locked_q;
  logic [CntW-1:0] count_q;
  ptr_t            wr_ptr_q;
  ptr_t            rd_ptr_q;
  idx_t            fifo_q [MaxOutstanding];
  logic            can_issue;
  logic            handshake;
  logic            pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + ptr_t'(1);
  endfunction

`ifdef DM_SBA_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_free = '0;
    for (int i = NrReq - 1; i >= 0; i--) begin
      if (req_i[i]) sel_free = idx_t'(i);
    end
  end
`else
  idx_t rr_ptr_q;

  // Search upward starting just past the last granted requester.
  always_comb begin
    logic found;
    idx_t cand;
    sel_free = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NrReq; i++) begin
      cand = idx_t'((32'(rr_ptr_q) + i) % NrReq);
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        sel_free = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= idx_t'(NrReq - 1);
    end else if (handshake) begin
      rr_ptr_q <= sel;
    end
  end
`endif

  // A stalled request stays locked so its payload cannot change under the bus.
  assign sel          = locked_q ? lock_idx_q : sel_free;
  assign can_issue    = (count_q < CntW'(MaxOutstanding));
  assign master_req_o = (|req_i) & can_issue;
  assign handshake    = master_req_o & master_gnt_i;
  assign pop          = master_r_valid_i & (count_q != '0);

  always_comb begin
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    gnt_o          = '0;
    r_valid_o      = '0;
    r_rdata_o      = '0;
    if (master_req_o) begin
      master_add_o   = add_i[sel];
      master_we_o    = we_i[sel];
      master_wdata_o = wdata_i[sel];
      master_be_o    = be_i[sel];
    end
    if (handshake) gnt_o[sel] = 1'b1;
    if (pop) begin
      r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
      r_rdata_o                   = master_r_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_o      <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      if (handshake) begin
        locked_q         <= 1'b0;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end else if (master_req_o) begin
        locked_q   <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (handshake && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!handshake && pop) begin
        count_q <= count_q - CntW'(1);
      end
      if (master_r_valid_i && (count_q == '0)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// Directed bench for dm_sba_arbiter: the bench plays the bus slave and scoreboards response routing.
module tb_dm_sba_arbiter;
  localparam int unsigned NrReq = 2;
  localparam int unsigned BW    = 32;
  localparam int unsigned W     = 1;

  logic                           clk;
  logic                           rst_n;
  logic [NrReq-1:0]               req_i;
  logic [NrReq-1:0][BW-1:0]       add_i;
  logic [NrReq-1:0]               we_i;
  logic [NrReq-1:0][BW-1:0]       wdata_i;
  logic [NrReq-1:0][BW/8-1:0]     be_i;
  logic [NrReq-1:0]               gnt_o;
  logic [NrReq-1:0]               r_valid_o;
  logic [BW-1:0]                  r_rdata_o;
  logic                           master_req_o;
  logic [BW-1:0]                  master_add_o;
  logic                           master_we_o;
  logic [BW-1:0]                  master_wdata_o;
  logic [BW/8-1:0]                master_be_o;
  logic                           master_gnt_i;
  logic                           master_r_valid_i;
  logic [BW-1:0]                  master_r_rdata_i;
  logic                           err_o;

  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  dm_sba_arbiter #(.NrReq(NrReq), .BusWidth(BW), .MaxOutstanding(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req_i),
    .add_i            (add_i),
    .we_i             (we_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_valid_o        (r_valid_o),
    .r_rdata_o        (r_rdata_o),
    .master_req_o     (master_req_o),
    .master_add_o     (master_add_o),
    .master_we_o      (master_we_o),
    .master_wdata_o   (master_wdata_o),
    .master_be_o      (master_be_o),
    .master_gnt_i     (master_gnt_i),
    .master_r_valid_i (master_r_valid_i),
    .master_r_rdata_i (master_r_rdata_i),
    .err_o            (err_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs just after the edge, then let logic settle.
  task automatic drive(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    req_i            = r;
    master_gnt_i     = g;
    master_r_valid_i = rv;
    master_r_rdata_i = rd;
    #1;
  endtask

  task automatic expect_grant(input int idx);
    chk("gnt", {62'd0, gnt_o}, 64'(1 << idx));
    chk("gnt_onehot", {63'd0, $onehot(gnt_o)}, 64'd1);
    exp_q.push_back(W'(idx));
  endtask

  task automatic expect_resp(input logic [31:0] data);
    logic [W-1:0] idx;
    if (exp_q.size() == 0) begin
      chk("r_valid_empty_sb", {62'd0, r_valid_o}, 64'd0);
    end else begin
      idx = exp_q.pop_front();
      chk("r_valid", {62'd0, r_valid_o}, 64'(1 << idx));
      chk("r_rdata", {32'd0, r_rdata_o}, {32'd0, data});
    end
  endtask

  initial begin
    int e;
    rst_n            = 1'b0;
    req_i            = '0;
    master_gnt_i     = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;
    add_i[0] = 32'h0000_0100;  add_i[1] = 32'h0000_0200;
    wdata_i[0] = 32'h0BAD_0000; wdata_i[1] = 32'hDEAD_0001;
    be_i[0] = 4'h3;             be_i[1] = 4'hF;
    we_i = 2'b10;
    #2;
    chk("rst_master_req", {63'd0, master_req_o}, 64'd0);
    chk("rst_gnt", {62'd0, gnt_o}, 64'd0);
    chk("rst_r_valid", {62'd0, r_valid_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_add", {32'd0, master_add_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both requesting every cycle, responses one cycle after each grant.
    for (int k = 0; k < 4; k++) begin
`ifdef DM_SBA_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 2;
`endif
      drive(2'b11, 1'b1, k > 0, 32'hC0DE_0000 + 32'(k));
      if (k > 0) expect_resp(32'hC0DE_0000 + 32'(k));
      chk("rr_add", {32'd0, master_add_o}, {32'd0, add_i[e]});
      chk("rr_we", {63'd0, master_we_o}, {63'd0, we_i[e]});
      chk("rr_wdata", {32'd0, master_wdata_o}, {32'd0, wdata_i[e]});
      chk("rr_be", {60'd0, master_be_o}, {60'd0, be_i[e]});
      expect_grant(e);
    end
    drive(2'b00, 1'b0, 1'b1, 32'hC0DE_0004);
    expect_resp(32'hC0DE_0004);
    chk("idle_master_req", {63'd0, master_req_o}, 64'd0);

    // Stall with requester 1; requester 0 joins but must not preempt.
    add_i[1] = 32'h0000_1000;
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("lock_c1_req", {63'd0, master_req_o}, 64'd1);
    chk("lock_c1_add", {32'd0, master_add_o}, 64'h1000);
    chk("lock_c1_gnt", {62'd0, gnt_o}, 64'd0);
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock_c2_add", {32'd0, master_add_o}, 64'h1000);
    chk("lock_c2_gnt", {62'd0, gnt_o}, 64'd0);
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock_c3_add", {32'd0, master_add_o}, 64'h1000);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("lock_c4_add", {32'd0, master_add_o}, 64'h1000);
    expect_grant(1);
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("lock_c5_add", {32'd0, master_add_o}, 64'h100);
    expect_grant(0);

    // Two outstanding: issue blocked even while a response pops this cycle.
    drive(2'b01, 1'b1, 1'b1, 32'hAAAA_0001);
    chk("full_master_req", {63'd0, master_req_o}, 64'd0);
    chk("full_gnt", {62'd0, gnt_o}, 64'd0);
    chk("full_add_zero", {32'd0, master_add_o}, 64'd0);
    expect_resp(32'hAAAA_0001);
    add_i[0] = 32'h0000_2000;
    drive(2'b01, 1'b1, 1'b1, 32'hBBBB_0000);
    chk("resume_master_req", {63'd0, master_req_o}, 64'd1);
    chk("resume_add", {32'd0, master_add_o}, 64'h2000);
    expect_resp(32'hBBBB_0000);
    expect_grant(0);
    drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    expect_resp(32'h1234_5678);

    // Stray response with nothing outstanding.
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0055);
    chk("stray_r_valid", {62'd0, r_valid_o}, 64'd0);
    chk("stray_err_before", {63'd0, err_o}, 64'd0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("stray_err_set", {63'd0, err_o}, 64'd1);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("stray_err_sticky", {63'd0, err_o}, 64'd1);

    // Reset with a transaction outstanding: it is forgotten.
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    expect_grant(0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_err", {63'd0, err_o}, 64'd0);
    chk("rst2_gnt", {62'd0, gnt_o}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0077);
    chk("post_rst_r_valid", {62'd0, r_valid_o}, 64'd0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("post_rst_err", {63'd0, err_o}, 64'd1);

    // After reset requester 0 wins first.
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    expect_grant(0);
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0099);
    expect_resp(32'h0000_0099);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_sba_arbiter.md
# dm_sba_arbiter

Shares the debug module's single system-bus master port between `NrReq` requesters (SBA engine, plus e.g. a trace or DMA agent) using the req/gnt/r_valid protocol of the DM master port. Round-robin arbitration, with grant locking while the bus stalls. Issued transactions are tracked in an in-order outstanding-ID FIFO so each read response is routed back to its issuer. Sits between the requesters and `master_*` of the debug top level.

## Interface
Parameters:
- `NrReq`, 2, number of requesters (≥2).
- `BusWidth`, 32, address/data width (32 or 64).
- `MaxOutstanding`, 2, depth of the outstanding-ID FIFO (≥1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_i` in NrReq: per-requester request. Held high with stable payload until granted.
- `add_i` in NrReq×BusWidth: per-requester address.
- `we_i` in NrReq: per-requester write enable.
- `wdata_i` in NrReq×BusWidth: per-requester write data.
- `be_i` in NrReq×BusWidth/8: per-requester byte enables.
- `gnt_o` out NrReq: one-hot grant.
- `r_valid_o` out NrReq: one-hot response valid.
- `r_rdata_o` out BusWidth: response data, broadcast to all requesters.
- `master_req_o` out 1: bus request.
- `master_add_o` out BusWidth: bus address.
- `master_we_o` out 1: bus write enable.
- `master_wdata_o` out BusWidth: bus write data.
- `master_be_o` out BusWidth/8: bus byte enables.
- `master_gnt_i` in 1: bus grant.
- `master_r_valid_i` in 1: bus response valid.
- `master_r_rdata_i` in BusWidth: bus response data.
- `err_o` out 1: sticky error; a response arrived with no transaction outstanding.

## Operation
- **Selection:**
  - Unlocked: first asserted `req_i` searching upward from `rr_ptr+1` (mod NrReq).
  - Locked: `lock_idx`.
- **Issue enable:** `can_issue = (count < MaxOutstanding)`. A pop in the same cycle does not free a slot; full blocks issue for that cycle.
- **Master outputs:**
  - `master_req_o = |req_i & can_issue`.
  - `master_add_o`/`we_o`/`wdata_o`/`be_o` are muxed from the selected requester.
  - All master payload outputs are 0 when `master_req_o` is low.
- **Grant:** `gnt_o[sel] = master_req_o & master_gnt_i`. `gnt_o` is combinational and never has more than one bit set.
- **Handshake (`master_req_o & master_gnt_i`):**
  - Push `sel` into the FIFO.
  - `rr_ptr <= sel`.
  - Clear the lock.
- **Lock:** when `master_req_o & ~master_gnt_i`, set `locked <= 1` and `lock_idx <= sel`. This keeps the payload stable across the stall, so a newly asserting higher-priority requester cannot preempt. The lock persists until that handshake completes.
- **Response routing:** on `master_r_valid_i` with `count > 0`:
  - `r_valid_o[fifo_head] = 1`.
  - `r_rdata_o = master_r_rdata_i`.
  - Pop the FIFO.
  - Writes also return a response and are routed identically.
- **Stray response:** `master_r_valid_i` with `count == 0` drives no `r_valid_o` bit and sets `err_o`. `err_o` clears only on reset.
- **Simultaneous push and pop:**
  - Allowed when `count < MaxOutstanding`; `count` is unchanged and the head advances.
  - Write and read pointers wrap modulo MaxOutstanding.
- **FIFO state:** `count` is $clog2(MaxOutstanding+1) bits wide and never exceeds MaxOutstanding.

## Timing
- Request path is zero-latency combinational from `req_i`/`master_gnt_i` to `master_*`/`gnt_o`.
- Response path is zero-latency combinational from `master_r_valid_i` to `r_valid_o`.
- Minimum response is one cycle after grant (bus-dependent). Back-to-back grants are possible every cycle while `count < MaxOutstanding`.
- **Reset values:**
  - Registers: `count = 0`, FIFO pointers = 0, `rr_ptr = NrReq-1` (requester 0 wins first), `locked = 0`, `lock_idx = 0`, `err_o = 0`.
  - All combinational outputs are 0 while `req_i` and `master_r_valid_i` are 0.
- **Reset mid-operation:** outstanding transactions are forgotten. A response arriving after reset release with `count == 0` sets `err_o`.

## Configuration
- Macro: `DM_SBA_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority (lowest index wins); `rr_ptr` is not implemented. The lock is still applied.
  - Undefined: round-robin as specified above.

## Test plan
- **Round-robin fairness:** `req_i = 2'b11` held, `master_gnt_i = 1` each cycle, responses 1 cycle later. Required: grants alternate 0,1,0,1, with `gnt_o` one-hot every cycle.
- **Lock on stall:**
  - Stimulus: requester 1 alone requests `add = 0x1000`, `master_gnt_i = 0` for 3 cycles; requester 0 raises `req` in cycle 2.
  - Required: `master_add_o` stays `0x1000`; grant goes to requester 1 in cycle 4, then requester 0.
- **Outstanding limit:** MaxOutstanding = 2, two grants issued with no response. Required: `master_req_o = 0` while `count == 2`, even with `master_r_valid_i` high that cycle; issue resumes the cycle after the pop.
- **Response routing:** grant to requester 1 then requester 0; responses with `0xAAAA0001` then `0xBBBB0000`. Required: `r_valid_o = 2'b10` with `0xAAAA0001`, then `2'b01` with `0xBBBB0000`.
- **Stray response:** `master_r_valid_i` pulse with `count == 0`. Required: `r_valid_o = 0`, `err_o` goes to 1 and stays 1 until `rst_ni` is asserted.
- **Fixed priority:** with `DM_SBA_ARB_FIXED_PRIO_EN` defined and `req_i = 2'b11` held, required: requester 0 is granted every cycle.
